// File: rtl/axi_rd_sched.sv
// axi_rd_sched
//   Shares one AXI read master between NUM_CLI DMA-style requesters.
//   Round-robin arbitration; each client transfer (up to 2^LEN_W-1 beats)
//   is cut into bursts of at most MAX_BURST beats that never cross a 4 KB
//   boundary. Returned beats are steered to the granted client.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cli_req/addr/len    per-client level request, byte address, beat count
//   cli_ack             1-cycle accept pulse
//   cli_rd_data/vld     shared read data, per-client beat strobe (comb)
//   cli_done            1-cycle transfer-complete pulse
//   len_err             burst ended with a beat count different from m_rd_len
//   busy                scheduler is not idle
//   m_rd_start/addr/len burst launch toward the read master
//   m_rd_data/vld/done  beats returned by the read master
module axi_rd_sched #(
  parameter int NUM_CLI   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CLI-1:0]        cli_req,
  input  logic [NUM_CLI*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLI*LEN_W-1:0]  cli_len,
  output logic [NUM_CLI-1:0]        cli_ack,
  output logic [DATA_W-1:0]         cli_rd_data,
  output logic [NUM_CLI-1:0]        cli_rd_vld,
  output logic [NUM_CLI-1:0]        cli_done,
  output logic                      len_err,
  output logic                      busy,
  output logic                      m_rd_start,
  output logic [ADDR_W-1:0]         m_rd_addr,
  output logic [7:0]                m_rd_len,
  input  logic [DATA_W-1:0]         m_rd_data,
  input  logic                      m_rd_vld,
  input  logic                      m_rd_done
);
  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = (NUM_CLI > 1) ? $clog2(NUM_CLI) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     ptr, gnt, sel;
  logic              sel_vld;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  rem_len, rem_nxt, sel_len;
  logic [7:0]        blen, bcnt, blen_nxt;
  logic [12:0]       room;

  function automatic logic [CW-1:0] nxt_ptr(input logic [CW-1:0] c);
    return (int'(c) == NUM_CLI - 1) ? '0 : c + 1'b1;
  endfunction

  // Round-robin pick: scan from the highest offset down so the lowest
  // offset from ptr is the last (winning) assignment.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    for (int i = NUM_CLI - 1; i >= 0; i--) begin
      if (cli_req[(int'(ptr) + i) % NUM_CLI]) begin
        sel_vld = 1'b1;
        sel     = CW'((int'(ptr) + i) % NUM_CLI);
      end
    end
  end

  assign sel_len = cli_len[int'(sel)*LEN_W +: LEN_W];

  // Beats left before the next 4 KB page; 13 bits so a page-aligned
  // address yields the full 4096 bytes.
  assign room = (13'd4096 - {1'b0, cur_addr[11:0]}) >> BSH;

  always_comb begin
    blen_nxt = 8'(MAX_BURST);
    if (rem_len < LEN_W'(MAX_BURST)) blen_nxt = rem_len[7:0];
    if (room < 13'(blen_nxt))        blen_nxt = room[7:0];
  end

  assign rem_nxt = rem_len - LEN_W'(blen);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      cur_addr   <= '0;
      rem_len    <= '0;
      blen       <= '0;
      bcnt       <= '0;
      cli_ack    <= '0;
      cli_done   <= '0;
      len_err    <= 1'b0;
      busy       <= 1'b0;
      m_rd_start <= 1'b0;
      m_rd_addr  <= '0;
      m_rd_len   <= '0;
    end else begin
      cli_ack    <= '0;
      cli_done   <= '0;
      len_err    <= 1'b0;
      m_rd_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            gnt          <= sel;
            cur_addr     <= cli_addr[int'(sel)*ADDR_W +: ADDR_W];
            rem_len      <= sel_len;
            cli_ack[sel] <= 1'b1;
            if (sel_len == '0) begin
              // Empty transfer completes on the spot, no bus traffic.
              cli_done[sel] <= 1'b1;
              ptr           <= nxt_ptr(sel);
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          // Launch registers are loaded here so they are live during ISSUE.
          blen       <= blen_nxt;
          bcnt       <= '0;
          m_rd_start <= 1'b1;
          m_rd_addr  <= cur_addr;
          m_rd_len   <= blen_nxt;
          state      <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (m_rd_vld) bcnt <= bcnt + 8'd1;
          if (m_rd_done) begin
            // done coincides with the last vld, so bcnt is one behind here.
            if (bcnt + 8'd1 != blen) len_err <= 1'b1;
            rem_len  <= rem_nxt;
            cur_addr <= cur_addr + (ADDR_W'(blen) << BSH);
            if (rem_nxt == '0) begin
              cli_done[gnt] <= 1'b1;
              ptr           <= nxt_ptr(gnt);
              state         <= IDLE;
              busy          <= 1'b0;
            end else begin
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cli_rd_data = m_rd_data;

  always_comb begin
    cli_rd_vld = '0;
    if (state == WAIT && m_rd_vld) cli_rd_vld[gnt] = 1'b1;
  end
endmodule

// File: tb/tb_axi_rd_sched.sv
module tb_axi_rd_sched;
  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NC-1:0]    cli_req;
  logic [NC*AW-1:0] cli_addr;
  logic [NC*LW-1:0] cli_len;
  logic [NC-1:0]    cli_ack, cli_rd_vld, cli_done;
  logic [DW-1:0]    cli_rd_data;
  logic             len_err, busy, m_rd_start;
  logic [AW-1:0]    m_rd_addr;
  logic [7:0]       m_rd_len;
  logic [DW-1:0]    m_rd_data;
  logic             m_rd_vld, m_rd_done;

  int checks = 0;
  int errors = 0;
  int vcnt[NC];

  axi_rd_sched #(.NUM_CLI(NC), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cli_req(cli_req), .cli_addr(cli_addr), .cli_len(cli_len),
    .cli_ack(cli_ack), .cli_rd_data(cli_rd_data), .cli_rd_vld(cli_rd_vld),
    .cli_done(cli_done), .len_err(len_err), .busy(busy),
    .m_rd_start(m_rd_start), .m_rd_addr(m_rd_addr), .m_rd_len(m_rd_len),
    .m_rd_data(m_rd_data), .m_rd_vld(m_rd_vld), .m_rd_done(m_rd_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    cli_req = '0; m_rd_vld = 1'b0; m_rd_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic req(input int c, input logic [31:0] a, input int l);
    cli_addr[c*AW +: AW] = a;
    cli_len[c*LW +: LW]  = LW'(l);
    cli_req[c]           = 1'b1;
  endtask

  // Waits for an ack pulse; optionally drops the acked request (hold-until-ack).
  task automatic wait_ack(input logic [NC-1:0] exp, input string tag, input bit drop);
    int n = 0;
    @(negedge clk);
    while (cli_ack == '0 && n < 50) begin @(negedge clk); n++; end
    chk(tag, cli_ack, exp);
    if (drop) cli_req = cli_req & ~exp;
  endtask

  task automatic wait_start(input logic [31:0] a, input int l, input string tag);
    int n = 0;
    while (!m_rd_start && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_start"}, m_rd_start, 1);
    chk({tag, "_addr"}, m_rd_addr, a);
    chk({tag, "_len"}, m_rd_len, l);
    @(negedge clk);
  endtask

  // Plays the read master: n beats, the last one flagged done if requested.
  task automatic beats(input int n, input bit done);
    for (int k = 0; k < n; k++) begin
      m_rd_vld  = 1'b1;
      m_rd_done = done && (k == n - 1);
      m_rd_data = 32'hD000_0000 + k;
      #1;
      for (int j = 0; j < NC; j++) if (cli_rd_vld[j]) vcnt[j]++;
      @(negedge clk);
    end
    m_rd_vld = 1'b0; m_rd_done = 1'b0;
  endtask

  task automatic xfer1(input int c, input logic [31:0] a, input string tag);
    wait_start(a, 1, tag);
    beats(1, 1'b1);
    chk({tag, "_done"}, cli_done, NC'(1) << c);
  endtask

  initial begin
    int v0;
    cli_req = '0; cli_addr = '0; cli_len = '0;
    m_rd_data = '0; m_rd_vld = 1'b0; m_rd_done = 1'b0;
    for (int j = 0; j < NC; j++) vcnt[j] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    m_rd_data = 32'hA5A5_5A5A;
    #1;
    chk("rst_ack", cli_ack, 0);
    chk("rst_done", cli_done, 0);
    chk("rst_vld", cli_rd_vld, 0);
    chk("rst_err", len_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", m_rd_start, 0);
    chk("rst_addr", m_rd_addr, 0);
    chk("rst_len", m_rd_len, 0);
    chk("rst_data", cli_rd_data, 32'hA5A5_5A5A);
    rst_n = 1'b1;
    @(negedge clk);

    // Burst split: 0x1000 / 40 beats -> 16, 16, 8
    req(0, 32'h1000, 40);
    wait_ack(2'b01, "t1_ack", 1'b1);
    chk("t1_busy", busy, 1);
    wait_start(32'h1000, 16, "t1_b0");
    beats(16, 1'b1);
    chk("t1_nodone0", cli_done, 0);
    chk("t1_gap", m_rd_start, 0);
    @(negedge clk);
    chk("t1_d2", m_rd_start, 1);
    wait_start(32'h1040, 16, "t1_b1");
    beats(16, 1'b1);
    chk("t1_nodone1", cli_done, 0);
    wait_start(32'h1080, 8, "t1_b2");
    beats(8, 1'b1);
    chk("t1_done", cli_done, 2'b01);
    chk("t1_err", len_err, 0);
    @(negedge clk);
    chk("t1_done1cyc", cli_done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_vcnt0", vcnt[0], 40);
    chk("t1_vcnt1", vcnt[1], 0);

    // 4 KB boundary: 0xFF8 / 10 -> (0xFF8,2), (0x1000,8)
    req(1, 32'h0FF8, 10);
    wait_ack(2'b10, "t2_ack", 1'b1);
    wait_start(32'h0FF8, 2, "t2_b0");
    beats(2, 1'b1);
    chk("t2_nodone", cli_done, 0);
    wait_start(32'h1000, 8, "t2_b1");
    beats(8, 1'b1);
    chk("t2_done", cli_done, 2'b10);
    chk("t2_vcnt1", vcnt[1], 10);

    // Round-robin
    do_reset();
    req(0, 32'h100, 1);
    req(1, 32'h200, 1);
    wait_ack(2'b01, "rr_a0", 1'b1);
    xfer1(0, 32'h100, "rr_x0");
    wait_ack(2'b10, "rr_a1", 1'b1);
    xfer1(1, 32'h200, "rr_x1");
    req(0, 32'h100, 1);
    req(1, 32'h200, 1);
    wait_ack(2'b01, "rr_b0", 1'b1);
    xfer1(0, 32'h100, "rr_y0");
    wait_ack(2'b10, "rr_b1", 1'b1);
    xfer1(1, 32'h200, "rr_y1");
    // Both held continuously: grants must alternate
    req(0, 32'h100, 1);
    req(1, 32'h200, 1);
    for (int k = 0; k < 4; k++) begin
      wait_ack((k % 2 == 0) ? 2'b01 : 2'b10, "rr_alt", 1'b0);
      xfer1(k % 2, (k % 2 == 0) ? 32'h100 : 32'h200, "rr_altx");
    end
    cli_req = '0;
    @(negedge clk);

    // Zero length
    do_reset();
    req(0, 32'h300, 0);
    wait_ack(2'b01, "z_ack", 1'b1);
    chk("z_done", cli_done, 2'b01);
    chk("z_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("z_quiet", {m_rd_start, busy, cli_ack, cli_done}, 0);
    end

    // Short burst: 0x2FF0 / 8 -> blen 4 (page edge), only 3 beats returned
    v0 = vcnt[0];
    req(0, 32'h2FF0, 8);
    wait_ack(2'b01, "sb_ack", 1'b1);
    wait_start(32'h2FF0, 4, "sb_b0");
    beats(3, 1'b1);
    chk("sb_err", len_err, 1);
    chk("sb_nodone", cli_done, 0);
    @(negedge clk);
    chk("sb_err1cyc", len_err, 0);
    wait_start(32'h3000, 4, "sb_b1");
    beats(4, 1'b1);
    chk("sb_done", cli_done, 2'b01);
    chk("sb_err2", len_err, 0);
    chk("sb_vcnt", vcnt[0] - v0, 7);

    // Mid-WAIT reset
    req(0, 32'h4000, 16);
    wait_ack(2'b01, "mr_ack", 1'b1);
    wait_start(32'h4000, 16, "mr_b0");
    beats(2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_rd_vld = 1'b1; m_rd_done = (k == 2);
      #1;
      chk("mr_vld", cli_rd_vld, 0);
      @(negedge clk);
    end
    m_rd_vld = 1'b0; m_rd_done = 1'b0;
    chk("mr_outs", {cli_ack, cli_done, len_err, busy, m_rd_start}, 0);
    chk("mr_maddr", {m_rd_addr, m_rd_len}, 0);
    req(1, 32'h500, 4);
    wait_ack(2'b10, "mr_ack1", 1'b1);
    wait_start(32'h500, 4, "mr_b1");
    v0 = vcnt[1];
    beats(4, 1'b1);
    chk("mr_done", cli_done, 2'b10);
    chk("mr_vcnt", vcnt[1] - v0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_rd_sched.md
# axi_rd_sched

Read scheduler that shares one AXI read master (`rd_start`/`rd_addr`/`rd_len` user port, `rd_vld`/`rd_done` return) between `NUM_CLI` requesters. It arbitrates round-robin and splits each client transfer of up to 65535 beats into bursts of at most `MAX_BURST` beats that never cross a 4 KB boundary. It routes returned beats to the granted client and signals completion per client. It sits between DMA-style clients and the AXI read master.

## Interface
- `NUM_CLI`, 2: number of requesters (2..4).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `BYTES = DATA_W/8`.
- `MAX_BURST`, 16: maximum beats per burst; power of two, 1..128.
- `LEN_W`, 16: client length width, in beats.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `cli_req`  in  NUM_CLI: level request; held until `cli_ack`.
- `cli_addr`  in  NUM_CLI*ADDR_W: start byte address, `BYTES`-aligned; stable while req is high.
- `cli_len`  in  NUM_CLI*LEN_W: beat count; stable while req is high.
- `cli_ack`  out  NUM_CLI: 1-cycle pulse when the request is accepted.
- `cli_rd_data`  out  DATA_W: equals `m_rd_data` (shared).
- `cli_rd_vld`  out  NUM_CLI: beat strobe for the granted client.
- `cli_done`  out  NUM_CLI: 1-cycle pulse when the whole transfer is complete.
- `len_err`  out  1: 1-cycle pulse when a burst ends with a wrong beat count.
- `busy`  out  1: high in every state except IDLE.
- `m_rd_start`  out  1: 1-cycle burst launch.
- `m_rd_addr`  out  ADDR_W: burst address; valid while `m_rd_start` is high.
- `m_rd_len`  out  8: burst beats (1..MAX_BURST); valid while `m_rd_start` is high.
- `m_rd_data`  in  DATA_W: returned data.
- `m_rd_vld`  in  1: returned beat strobe.
- `m_rd_done`  in  1: last-beat strobe; coincides with the final `m_rd_vld`.

## Operation
- FSM states: IDLE, CALC, ISSUE, WAIT.
- **IDLE.** If any `cli_req` is high, grant `g` = first requester at or after priority pointer `ptr`, wrapping. Latch `cur_addr`, `rem_len`, and `g`. Pulse `cli_ack[g]`.
  - If `len` is 0: pulse `cli_done[g]` in the same cycle, set `ptr = g+1` (mod NUM_CLI), stay in IDLE.
  - Otherwise go to CALC.
- **CALC.** Register `blen = min(rem_len, MAX_BURST, (4096 - cur_addr[11:0]) / BYTES)`. Clear the beat counter `bcnt`. Go to ISSUE.
- **ISSUE.** Drive `m_rd_start = 1`, `m_rd_addr = cur_addr`, `m_rd_len = blen` for one cycle. Go to WAIT.
- **WAIT.**
  - `cli_rd_vld[g] = m_rd_vld`; this is combinational, and only in WAIT.
  - `bcnt` increments on each `m_rd_vld`.
  - On `m_rd_done`:
    - Pulse `len_err` if `bcnt + 1 != blen`.
    - Update `rem_len -= blen` and `cur_addr += blen*BYTES` (wraps modulo 2^ADDR_W).
    - If the new `rem_len` is 0: pulse `cli_done[g]`, set `ptr = g+1`, go to IDLE.
    - Otherwise go to CALC.
- `m_rd_vld` and `m_rd_done` outside WAIT are ignored: no `cli_rd_vld`, no counter change.
- Requests are sampled only in IDLE. A client dropping `req` before ack is simply not granted.
- A granted client is never preempted.
- Arithmetic widths: `blen` and `bcnt` are 8 bits. The 4 KB term is computed in 13 bits.

## Timing
- Reset values:
  - All outputs 0 except `cli_rd_data`, which follows `m_rd_data`.
  - `ptr` = 0; state = IDLE.
- Latencies:
  - Request seen in IDLE at cycle T: `cli_ack` at T+1, CALC at T+1, `m_rd_start` at T+2.
  - `m_rd_done` at cycle D: next `m_rd_start` at D+2, or `cli_done` at D+1.
- Back-to-back: a new grant can be sampled in the cycle `cli_done` is high (state is already IDLE). `cli_ack` of the next client follows 1 cycle later.
- Registered outputs: `m_rd_*`, `cli_ack`, `cli_done`, `len_err`, `busy`. Combinational outputs: `cli_rd_vld`, `cli_rd_data`.
- Reset mid-transfer: return to IDLE in the next cycle. In-flight downstream beats are dropped (never forwarded). No `cli_done` is issued for the aborted transfer.

## Test plan
- **Burst split.** BYTES = 4, MAX_BURST = 16. Client0 addr 0x1000, len 40 → bursts (0x1000,16), (0x1040,16), (0x1080,8). Exactly 40 `cli_rd_vld[0]` and one `cli_done[0]`.
- **4 KB boundary.** Client1 addr 0x0FF8, len 10 → bursts (0x0FF8,2), (0x1000,8). `cli_done[1]` 1 cycle after the second `m_rd_done`.
- **Round-robin.**
  - After reset, clients 0 and 1 request simultaneously → ack order 0, 1.
  - Both re-request → order 0, 1 again.
  - Client0 held continuously with client1 → strict alternation.
- **Zero length.** Client0 len 0 → `cli_ack[0]` and `cli_done[0]` in the same cycle. No `m_rd_start`. `busy` stays 0.
- **Short burst.** Downstream returns 3 beats with `m_rd_done` for a `blen` = 4 burst → `len_err` pulses once. Transfer continues with `rem_len` reduced by 4.
- **Mid-WAIT reset.**
  - Assert `rst_n = 0` for 1 cycle during a burst; stray `m_rd_vld` afterwards → no `cli_rd_vld`, all outputs 0.
  - A new client1 request then completes normally.
